// File: rtl/seg_scan_decoder_pkg.sv
// Shared constants for decoding a scanned 4-digit seven-segment display bus.
// Segment bits are {g,f,e,d,c,b,a}; digit selects are active-low.
package seg_pkg;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h67;
    localparam logic [6:0] SEG_DASH = 7'h40;

    localparam logic [3:0] CODE_DASH = 4'hE;
    localparam logic [3:0] CODE_BAD  = 4'hF;

    localparam logic [3:0] SEL_UNIT = 4'b1110;
    localparam logic [3:0] SEL_TEN  = 4'b1101;
    localparam logic [3:0] SEL_HUN  = 4'b1011;
    localparam logic [3:0] SEL_THO  = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_HELD
    } scan_state_e;

    function automatic logic sel_is_valid(input logic [3:0] sel);
        return (sel == SEL_UNIT) || (sel == SEL_TEN) ||
               (sel == SEL_HUN)  || (sel == SEL_THO);
    endfunction

endpackage

// File: rtl/seg_scan_decoder_seg7_to_bcd.sv
// Combinational seven-segment pattern to BCD decoder.
// Dash decodes to CODE_DASH without error; anything unknown gives CODE_BAD with err.
module seg7_to_bcd
    import seg_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] code_o,
    output logic       err_o
);

    always_comb begin
        code_o = CODE_BAD;
        case (seg_i)
            SEG_0:    code_o = 4'd0;
            SEG_1:    code_o = 4'd1;
            SEG_2:    code_o = 4'd2;
            SEG_3:    code_o = 4'd3;
            SEG_4:    code_o = 4'd4;
            SEG_5:    code_o = 4'd5;
            SEG_6:    code_o = 4'd6;
            SEG_7:    code_o = 4'd7;
            SEG_8:    code_o = 4'd8;
            SEG_9:    code_o = 4'd9;
            SEG_DASH: code_o = CODE_DASH;
            default:  code_o = CODE_BAD;
        endcase
        err_o = (code_o == CODE_BAD);
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Reconstructs four BCD digits from a multiplexed seven-segment display bus,
// pulsing frame_valid once all positions are freshly captured and flagging a stalled scan.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int unsigned SETTLE  = 2,
    parameter int unsigned TIMEOUT = 100_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sel_in,
    input  logic [6:0] seg_in,
    output logic [3:0] unit,
    output logic [3:0] ten,
    output logic [3:0] hun,
    output logic [3:0] tho,
    output logic [3:0] digit_err,
    output logic       frame_valid,
    output logic       stale
);

    localparam int unsigned SW = $clog2(SETTLE + 1);
    localparam int unsigned IW = $clog2(TIMEOUT + 1);

    logic [3:0]      sel_q, sel_d;
    logic [6:0]      seg_q;
    scan_state_e     state_q, state_d;
    logic [SW-1:0]   settle_cnt_q, settle_cnt_d;
    logic [IW-1:0]   idle_cnt_q, idle_cnt_d;
    logic [3:0]      seen_q, seen_d;
    logic [3:0][3:0] shadow_q, shadow_d;
    logic [3:0]      shadow_err_q, shadow_err_d;
    logic [3:0][3:0] dout_q, dout_d;
    logic [3:0]      err_q, err_d;
    logic            fv_q, fv_d;
    logic            stale_q, stale_d;

    logic [3:0]      dec_code;
    logic            dec_err;
    logic            sel_change;
    logic            capture;

    seg7_to_bcd u_dec (
        .seg_i  (seg_q),
        .code_o (dec_code),
        .err_o  (dec_err)
    );

    // FSM tracks the value sel_q takes at this edge, so a change restarts settling on the same edge.
    assign sel_d      = sel_in;
    assign sel_change = (sel_d != sel_q);

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        capture      = 1'b0;
        if (sel_change) begin
            settle_cnt_d = '0;
            state_d      = sel_is_valid(sel_d) ? ST_SETTLE : ST_IDLE;
        end else begin
            case (state_q)
                ST_SETTLE: begin
                    if (settle_cnt_q + SW'(1) == SW'(SETTLE)) begin
                        capture      = 1'b1;
                        settle_cnt_d = '0;
                        state_d      = ST_HELD;
                    end else begin
                        settle_cnt_d = settle_cnt_q + SW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        seen_d       = seen_q;
        shadow_d     = shadow_q;
        shadow_err_d = shadow_err_q;
        dout_d       = dout_q;
        err_d        = err_q;
        fv_d         = 1'b0;
        stale_d      = stale_q;
        idle_cnt_d   = (idle_cnt_q == IW'(TIMEOUT)) ? idle_cnt_q : idle_cnt_q + IW'(1);
        if (capture) begin
            idle_cnt_d = '0;
            for (int unsigned i = 0; i < 4; i++) begin
                if (!sel_q[i]) begin
                    shadow_d[i]     = dec_code;
                    shadow_err_d[i] = dec_err;
                end
            end
            seen_d = seen_q | ~sel_q;
            // Outputs load from the updated shadow so the completing digit is included.
            if (seen_d == '1) begin
                dout_d  = shadow_d;
                err_d   = shadow_err_d;
                fv_d    = 1'b1;
                seen_d  = '0;
                stale_d = 1'b0;
            end
        end else if (idle_cnt_d == IW'(TIMEOUT)) begin
            stale_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q        <= '1;
            seg_q        <= '0;
            state_q      <= ST_IDLE;
            settle_cnt_q <= '0;
            idle_cnt_q   <= '0;
            seen_q       <= '0;
            shadow_q     <= {4{CODE_DASH}};
            shadow_err_q <= '0;
            dout_q       <= {4{CODE_DASH}};
            err_q        <= '0;
            fv_q         <= 1'b0;
            stale_q      <= 1'b0;
        end else begin
            sel_q        <= sel_d;
            seg_q        <= seg_in;
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            seen_q       <= seen_d;
            shadow_q     <= shadow_d;
            shadow_err_q <= shadow_err_d;
            dout_q       <= dout_d;
            err_q        <= err_d;
            fv_q         <= fv_d;
            stale_q      <= stale_d;
        end
    end

    assign unit        = dout_q[0];
    assign ten         = dout_q[1];
    assign hun         = dout_q[2];
    assign tho         = dout_q[3];
    assign digit_err   = err_q;
    assign frame_valid = fv_q;
    assign stale       = stale_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: a dwell-level display-bus model predicts
// frames and per-cycle status; a negedge monitor compares against the DUT.
module tb_seg_scan_decoder;

    localparam int unsigned SETTLE  = 2;
    localparam int unsigned TIMEOUT = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sel_in;
    logic [6:0] seg_in;
    logic [3:0] unit, ten, hun, tho, digit_err;
    logic       frame_valid, stale;

    always #5 clk = ~clk;

    seg_scan_decoder #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .sel_in      (sel_in),
        .seg_in      (seg_in),
        .unit        (unit),
        .ten         (ten),
        .hun         (hun),
        .tho         (tho),
        .digit_err   (digit_err),
        .frame_valid (frame_valid),
        .stale       (stale)
    );

    typedef struct packed {
        logic [3:0] tho, hun, ten, unit;
        logic [3:0] err;
    } frame_t;

    typedef struct packed {
        logic   fv;
        logic   stale;
        frame_t out;
    } stat_t;

    frame_t exp_q[$];
    stat_t  stat_q[$];
    int     checks = 0;
    int     errors = 0;
    bit     done = 0;
    bit     final_done = 0;

    logic [6:0] digit_pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                   7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h67};

    // Reference model state: per-position shadow, seen set, last frame, stall tracking.
    bit         m_seen [4];
    logic [3:0] m_code [4];
    logic       m_err  [4];
    frame_t     m_out;
    int         since_cap;
    bit         m_stale;
    logic [6:0] cur_seg;
    logic [3:0] cur_sel;

    function automatic logic [4:0] ref_decode(input logic [6:0] p);
        for (int d = 0; d < 10; d++)
            if (digit_pat[d] == p) return {1'b0, 4'(d)};
        if (p == 7'h40) return {1'b0, 4'hE};
        return {1'b1, 4'hF};
    endfunction

    task automatic model_edge(input bit r, input bit cap, input int pos, input logic [6:0] pat);
        logic [4:0] dec;
        bit fv;
        fv = 0;
        if (r) begin
            for (int i = 0; i < 4; i++) m_seen[i] = 0;
            m_out     = '{4'hE, 4'hE, 4'hE, 4'hE, 4'b0000};
            since_cap = 0;
            m_stale   = 0;
        end else if (cap) begin
            dec          = ref_decode(pat);
            m_code[pos]  = dec[3:0];
            m_err[pos]   = dec[4];
            m_seen[pos]  = 1;
            since_cap    = 0;
            if (m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3]) begin
                m_out = '{m_code[3], m_code[2], m_code[1], m_code[0],
                          {m_err[3], m_err[2], m_err[1], m_err[0]}};
                exp_q.push_back(m_out);
                for (int i = 0; i < 4; i++) m_seen[i] = 0;
                m_stale = 0;
                fv = 1;
            end
        end else begin
            since_cap++;
            if (since_cap >= int'(TIMEOUT)) m_stale = 1;
        end
        stat_q.push_back('{fv, m_stale, m_out});
    endtask

    task automatic drive(input logic r, input logic [3:0] s, input logic [6:0] g);
        rst = r; sel_in = s; seg_in = g;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 4'hF, 7'h00);
            model_edge(1'b1, 0, 0, 7'h00);
        end
        cur_seg = 7'h00;
        cur_sel = 4'hF;
    endtask

    // One dwell of select s; seg lags by `lag` cycles. Captured iff a single select
    // is low and the dwell reaches SETTLE+1 cycles; seg sampled SETTLE-1 cycles in.
    task automatic run(input logic [3:0] s, input logic [6:0] pat, input int len, input int lag);
        logic [6:0] old_seg, g, cap_pat;
        bit ok;
        int pos;
        old_seg = cur_seg;
        cap_pat = pat;
        ok = ($countones(~s) == 1);
        pos = 0;
        for (int i = 0; i < 4; i++) if (s[i] == 1'b0) pos = i;
        for (int i = 0; i < len; i++) begin
            g = (i < lag) ? old_seg : pat;
            if (i == int'(SETTLE) - 1) cap_pat = g;
            drive(1'b0, s, g);
            model_edge(1'b0, ok && (i == int'(SETTLE)), pos, cap_pat);
        end
        cur_seg = pat;
        cur_sel = s;
    endtask

    task automatic scan_digits(input int th, input int h, input int t, input int u, input int len);
        run(4'b1110, digit_pat[u],  len, 1);
        run(4'b1101, digit_pat[t],  len, 1);
        run(4'b1011, digit_pat[h],  len, 1);
        run(4'b0111, digit_pat[th], len, 1);
    endtask

    stat_t  st;
    frame_t fr;

    always @(negedge clk) begin
        if (stat_q.size() > 0) begin
            st = stat_q.pop_front();
            checks++;
            if ({frame_valid, stale, tho, hun, ten, unit, digit_err} !== st) begin
                errors++;
                $display("FAIL status t=%0t got fv=%b stale=%b out=%h%h%h%h err=%b, exp fv=%b stale=%b out=%h%h%h%h err=%b",
                         $time, frame_valid, stale, tho, hun, ten, unit, digit_err,
                         st.fv, st.stale, st.out.tho, st.out.hun, st.out.ten, st.out.unit, st.out.err);
            end
            if (frame_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL frame t=%0t unexpected frame_valid, got %h%h%h%h err=%b, exp none",
                             $time, tho, hun, ten, unit, digit_err);
                end else begin
                    fr = exp_q.pop_front();
                    if ({tho, hun, ten, unit, digit_err} !== fr) begin
                        errors++;
                        $display("FAIL frame t=%0t got %h%h%h%h err=%b, exp %h%h%h%h err=%b",
                                 $time, tho, hun, ten, unit, digit_err,
                                 fr.tho, fr.hun, fr.ten, fr.unit, fr.err);
                    end
                end
            end
        end else if (done && !final_done) begin
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL pending_frames got %0d left, exp 0", exp_q.size());
            end
            final_done = 1;
        end
    end

    initial begin
        logic [3:0] s;
        logic [6:0] p;
        int r;
        logic [3:0] multi [4];
        multi = '{4'b1100, 4'b0000, 4'b1010, 4'b0101};
        rst = 1'b1; sel_in = 4'hF; seg_in = 7'h00;
        do_reset(3);

        // Nominal 1234 with 8-cycle dwells and one-cycle seg lag
        repeat (3) scan_digits(1, 2, 3, 4, 8);

        // Bad pattern on units, then dash on units
        run(4'b1110, 7'h01, 8, 1);
        run(4'b1101, digit_pat[3], 8, 1);
        run(4'b1011, digit_pat[2], 8, 1);
        run(4'b0111, digit_pat[1], 8, 1);
        run(4'b1110, 7'h40, 8, 1);
        run(4'b1101, digit_pat[3], 8, 1);
        run(4'b1011, digit_pat[2], 8, 1);
        run(4'b0111, digit_pat[1], 8, 1);

        // Glitches, short dwell and multi-low selects
        run(4'b1110, digit_pat[9], 5, 1);
        run(4'b1111, digit_pat[9], 1, 0);
        run(4'b1110, digit_pat[9], 4, 0);
        run(4'b1101, digit_pat[8], 2, 1);
        run(4'b1100, digit_pat[0], 3, 0);
        run(4'b1011, digit_pat[7], 8, 1);
        run(4'b1111, digit_pat[7], 2, 0);
        run(4'b1101, digit_pat[8], 8, 1);
        run(4'b0111, digit_pat[6], 8, 1);

        // Stall on units, then resume
        run(4'b1110, digit_pat[5], 100, 1);
        run(4'b1101, digit_pat[6], 8, 1);
        run(4'b1011, digit_pat[7], 8, 1);
        run(4'b0111, digit_pat[8], 8, 1);

        // Reset after three captures, then a fresh scan
        run(4'b1110, digit_pat[1], 8, 1);
        run(4'b1101, digit_pat[2], 8, 1);
        run(4'b1011, digit_pat[3], 8, 1);
        do_reset(2);
        scan_digits(5, 6, 7, 8, 8);

        // Random bus traffic
        for (int n = 0; n < 120; n++) begin
            do begin
                r = $urandom_range(0, 19);
                if (r < 16)      s = 4'hF ^ (4'b0001 << (r % 4));
                else if (r < 18) s = 4'hF;
                else             s = multi[$urandom_range(0, 3)];
            end while (s == cur_sel);
            r = $urandom_range(0, 11);
            if (r < 10)       p = digit_pat[r];
            else if (r == 10) p = 7'h40;
            else              p = 7'($urandom);
            run(s, p, $urandom_range(1, 9), $urandom_range(0, 1));
        end

        run(4'hF, 7'h00, 4, 0);
        done = 1;
        for (int i = 0; i < 20 && !final_done; i++) @(posedge clk);
        if (!final_done) $display("FAIL monitor_drain got incomplete, exp drained");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side counterpart of the stopwatch's multiplexed 4-digit seven-segment driver: samples the active-low digit-select and active-high segment lines of a scanned display bus and reconstructs the four BCD digits. Used as an in-system loopback checker and as a bench/board monitor for the display path. It emits a one-cycle `frame_valid` pulse each time all four positions have been freshly captured, and flags undecodable patterns and a stalled scan.

## Interface
- `SETTLE`, default 2: cycles `sel_q` must be unchanged before `seg_q` is captured; must be ≥1.
- `TIMEOUT`, default 100_000: cycles without any capture before `stale` asserts. This is 2 ms at 50 MHz, twice the driver's digit dwell.
- `clk`  in  1: system clock, 50 MHz.
- `rst`  in  1: synchronous reset, active-high.
- `sel_in`  in  4: digit select, active-low. Bit0 = units, bit1 = tens, bit2 = hundreds, bit3 = thousands.
- `seg_in`  in  7: segments, active-high. Bit6..0 = g,f,e,d,c,b,a.
- `unit`, `ten`, `hun`, `tho`  out  4 each: last complete frame, decoded.
- `digit_err`  out  4: per-position flag meaning the last frame held an undecodable pattern.
- `frame_valid`  out  1: one-cycle pulse when the outputs update.
- `stale`  out  1: no capture for `TIMEOUT` cycles.

## Operation
- `sel_in` and `seg_in` are registered once into `sel_q` and `seg_q` before any use.
- **Decode table:**
  - 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x07→7, 0x7F→8, 0x67→9.
  - 0x40 (dash) → 4'hE, no error.
  - Any other pattern → 4'hF with error bit set.
- **A valid select** is exactly one bit low in `sel_q`. Both 4'b1111 and multi-low values are invalid: they are never captured, and they hold the settle FSM in IDLE.
- **FSM:**
  - IDLE: `sel_q` invalid. Goes to SETTLE when `sel_q` is valid.
  - SETTLE: `settle_cnt` counts cycles of an unchanged, valid `sel_q`. Reaching `SETTLE` triggers a capture and moves to HELD. Any change of `sel_q` restarts the count from 0, or goes to IDLE if the new value is invalid.
  - HELD: no further capture. A change to a valid value goes to SETTLE with count 0; a change to an invalid value goes to IDLE.
- **Capture:** writes the decoded digit and error bit into a shadow slot for that position and sets the matching bit of a 4-bit `seen` map.
  - Re-capturing a position already in `seen` overwrites its shadow slot.
  - Capture order is irrelevant.
- **Frame complete:** on the capture edge that makes `seen` = 4'b1111:
  - all four outputs and `digit_err` load from the shadow, including the digit being captured on that edge;
  - `frame_valid` is high for the following cycle only;
  - `seen` clears.
- **Stale:** `idle_cnt` increments every cycle and clears on each capture. `stale` sets when `idle_cnt` reaches `TIMEOUT` and clears on the next `frame_valid`. `idle_cnt` saturates at `TIMEOUT`; it does not wrap.

## Timing
- **Reset values:** `unit`/`ten`/`hun`/`tho` = 4'hE, `digit_err` = 0, `frame_valid` = 0, `stale` = 0, FSM = IDLE, `seen` = 0, all counters 0. Reset applied mid-dwell or mid-frame discards partial captures.
- **Capture latency:** if `sel_in` changes before edge N, then `sel_q` changes at N and the capture uses the `seg_q` present at edge N+`SETTLE`. With `SETTLE` = 2, this absorbs the driver's one-cycle seg-after-sel register lag.
- **Output latency:** outputs update at the completing capture edge; `frame_valid` is visible in that same cycle.
- **Simultaneous events:** a capture on the same edge that `idle_cnt` would reach `TIMEOUT` wins, so `stale` does not set.
- **Throughput:** one capture per dwell, and each dwell must last at least `SETTLE`+1 cycles. Shorter dwells are ignored.

## Structure
- Package `seg_pkg` holds:
  - the ten digit segment constants and `SEG_DASH` = 7'h40;
  - the code constants `CODE_DASH` = 4'hE and `CODE_BAD` = 4'hF;
  - the one-hot-low select constants `SEL_UNIT` … `SEL_THO`.
- Sub-module `seg7_to_bcd`: combinational, input 7-bit pattern, outputs 4-bit code and `err`; instantiated once on `seg_q`.
- Top level contains the input registers, FSM, counters, shadow registers, `seen` map and output registers.

## Test plan
- **Nominal scan:** `SETTLE`=2, `TIMEOUT`=64. Drive a digits-1234 scan (units=4) with 8-cycle dwells in order units→thousands → `frame_valid` pulses once per 32 cycles; `unit`=4, `ten`=3, `hun`=2, `tho`=1; `digit_err`=0.
- **Seg lag:** on each `sel` switch, `seg` still shows the previous digit for 1 cycle → the decoded frame is still exact.
- **Bad pattern:** units shows 0x01 → `unit`=4'hF, `digit_err`=4'b0001. Units shows 0x40 → `unit`=4'hE, no error.
- **Glitch/invalid:** a 1-cycle 4'b1111 inserted mid-dwell, then a 2-cycle dwell, then a multi-low 4'b1100 → none of these are captured; `frame_valid` is not pulsed until all four positions are properly captured.
- **Stall:** hold `sel_in` = 4'b1110 for 100 cycles → `stale`=1 at 64 cycles after the capture, outputs unchanged. Resume scanning → `stale` clears with the next `frame_valid`.
- **Reset:** assert `rst` after 3 captures, release, then scan 4 digits → exactly one `frame_valid` after the fourth new capture; no output change before it (outputs stay 4'hE).
